// File: rtl/timer_unit_pkg.sv
// timer_unit_pkg: shared FSM state type and TAC field constants for the timer
package timer_unit_pkg;
  typedef enum logic [1:0] {T_RUN, T_OVF, T_RLD} timer_state_t;
  localparam int TAC_ENABLE_BIT = 2;
  localparam int TAC_TAP_4K = 9;
  localparam int TAC_TAP_262K = 3;
  localparam int TAC_TAP_65K = 5;
  localparam int TAC_TAP_16K = 7;
endpackage

// File: rtl/timer_tap_edge.sv
// timer_tap_edge: tap mux and falling-edge detector on post-write divider/TAC values; TIMER_DIV_GLITCH_EN lets
// write-induced edges count, otherwise edges in cycles with a DIV or TAC write are suppressed
module timer_tap_edge
  import timer_unit_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div_cnt,
  input  logic [2:0]           tac,
  input  logic                 wr,
  output logic                 tick_fall
);
  logic tap, tick_d, tick_q;
  logic unused_in;
  assign unused_in = ^{div_cnt, wr};
  always_comb begin
    tap = tac[1] ? (tac[0] ? div_cnt[TAC_TAP_16K] : div_cnt[TAC_TAP_65K])
                 : (tac[0] ? div_cnt[TAC_TAP_262K] : div_cnt[TAC_TAP_4K]);
    tick_d = tac[TAC_ENABLE_BIT] & tap;
`ifdef TIMER_DIV_GLITCH_EN
    tick_fall = tick_q & ~tick_d;
`else
    tick_fall = tick_q & ~tick_d & ~wr;
`endif
  end
  always_ff @(posedge clk) tick_q <= !rst ? 1'b0 : tick_d;
endmodule

// File: rtl/timer_unit.sv
// timer_unit: DIV/TIMA/TMA/TAC timer with delayed TMA reload and one-cycle irq; TIMER_DIV_GLITCH_EN selects
// whether DIV/TAC writes can clock TIMA
module timer_unit
  import timer_unit_pkg::*;
#(
  parameter int DIV_WIDTH    = 16,
  parameter int RELOAD_DELAY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_wr,
  input  logic       tima_wr,
  input  logic       tma_wr,
  input  logic       tac_wr,
  input  logic [7:0] wdata,
  output logic [7:0] div,
  output logic [7:0] tima,
  output logic [7:0] tma,
  output logic [7:0] tac,
  output logic       irq_timer
);
  localparam logic [3:0] RCNT_INIT = 4'(RELOAD_DELAY - 1);
  logic [DIV_WIDTH-1:0] div_cnt_d, div_cnt_q;
  logic [7:0] tima_d, tima_q, tma_d, tma_q;
  logic [2:0] tac_d, tac_q;
  logic [3:0] rcnt_d, rcnt_q;
  logic irq_d, irq_q, tick_fall;
  timer_state_t state_d, state_q;
  timer_tap_edge #(.DIV_WIDTH(DIV_WIDTH)) u_tap (
    .clk      (clk),
    .rst      (rst),
    .div_cnt  (div_cnt_d),
    .tac      (tac_d),
    .wr       (div_wr | tac_wr),
    .tick_fall(tick_fall)
  );
  always_comb begin
    div_cnt_d = div_wr ? '0 : div_cnt_q + DIV_WIDTH'(1);
    tma_d = tma_wr ? wdata : tma_q;
    tac_d = tac_wr ? wdata[2:0] : tac_q;
    tima_d = tima_q;
    rcnt_d = rcnt_q;
    state_d = state_q;
    irq_d = 1'b0;
    case (state_q)
      T_RUN: begin
        if (tima_wr) tima_d = wdata;
        else if (tick_fall && tima_q == 8'hFF) begin
          tima_d = 8'h00;
          rcnt_d = RCNT_INIT;
          state_d = T_OVF;
        end else if (tick_fall) tima_d = tima_q + 8'd1;
      end
      T_OVF: begin
        if (tima_wr) begin
          tima_d = wdata;
          state_d = T_RUN;
        end else if (rcnt_q == 4'd0) begin
          tima_d = tma_d;
          irq_d = 1'b1;
          state_d = T_RLD;
        end else rcnt_d = rcnt_q - 4'd1;
      end
      T_RLD: begin
        tima_d = tma_wr ? wdata : tima_q;
        state_d = T_RUN;
      end
      default: state_d = T_RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q <= '0;
      tima_q <= 8'h00;
      tma_q <= 8'h00;
      tac_q <= 3'b000;
      rcnt_q <= 4'd0;
      irq_q <= 1'b0;
      state_q <= T_RUN;
    end else begin
      div_cnt_q <= div_cnt_d;
      tima_q <= tima_d;
      tma_q <= tma_d;
      tac_q <= tac_d;
      rcnt_q <= rcnt_d;
      irq_q <= irq_d;
      state_q <= state_d;
    end
  end
  assign div = div_cnt_q[DIV_WIDTH-1 -: 8];
  assign tima = tima_q;
  assign tma = tma_q;
  assign tac = {5'b0, tac_q};
  assign irq_timer = irq_q;
endmodule
